// File: rtl/mac_int_multilane.sv
// rtl/mac_int_multilane.sv - LANES-wide signed multiply-accumulate joining two input streams
//
// Purpose:
//   Runs LANES parallel signed MAC lanes fed by two joined valid/ready/last
//   streams (A, B). Stage 1 registers the per-lane products. Stage 2
//   accumulates them with saturation into ACCW-bit lane accumulators.
//   The sums go out on one stream, which also carries per-lane sticky
//   overflow flags. MODE 0 emits the running sum on every beat. MODE 1
//   emits only on the LAST beat of a packet.
//
// Ports:
//   CLK, RESET                    clock; synchronous active-high reset
//   IN_DATA_A/IN_VALID_A/IN_LAST_A A stream, lane i = [i*W +: W]
//   IN_READY_A                     A stream ready (asserted together with B)
//   IN_DATA_B/IN_VALID_B/IN_LAST_B B stream, lane i = [i*W +: W]
//   IN_READY_B                     B stream ready
//   OUT_MAC_DATA                   lane sums, lane i = [i*ACCW +: ACCW]
//   OUT_MAC_VALID/OUT_MAC_READY    output handshake
//   OUT_MAC_LAST                   output beat closes a packet
//   OUT_MAC_OVERFLOW               per-lane saturation seen so far in the packet
//   LAST_ERR                       sticky: A/B LAST disagreed on an accepted beat
module mac_int_multilane #(
  parameter int W     = 16,
  parameter int LANES = 4,
  parameter int ACCW  = 40,
  parameter int MODE  = 0
) (
  input  logic                    CLK,
  input  logic                    RESET,
  output logic                    IN_READY_A,
  input  logic [W*LANES-1:0]      IN_DATA_A,
  input  logic                    IN_VALID_A,
  input  logic                    IN_LAST_A,
  output logic                    IN_READY_B,
  input  logic [W*LANES-1:0]      IN_DATA_B,
  input  logic                    IN_VALID_B,
  input  logic                    IN_LAST_B,
  output logic [ACCW*LANES-1:0]   OUT_MAC_DATA,
  output logic                    OUT_MAC_VALID,
  input  logic                    OUT_MAC_READY,
  output logic                    OUT_MAC_LAST,
  output logic [LANES-1:0]        OUT_MAC_OVERFLOW,
  output logic                    LAST_ERR
);

  localparam int PW = 2 * W;
  localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};

  logic                   s1_valid;
  logic                   s1_last;
  logic signed [PW-1:0]   s1_prod  [LANES];
  logic signed [PW-1:0]   prod_c   [LANES];
  logic signed [ACCW:0]   sum_c    [LANES];
  logic signed [ACCW-1:0] acc      [LANES];
  logic signed [ACCW-1:0] acc_next [LANES];
  logic [LANES-1:0]       ovf;
  logic [LANES-1:0]       new_ovf;
  logic                   fire;
  logic                   emit;
  logic                   advance;
  logic                   s1_free;

  // Operands are sign-extended to the product width first, so the low 2W bits
  // of the unsigned multiply equal the signed product.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_c[i] = {{W{IN_DATA_A[i*W+W-1]}}, IN_DATA_A[i*W +: W]} *
                  {{W{IN_DATA_B[i*W+W-1]}}, IN_DATA_B[i*W +: W]};
    end
  end

  // One guard bit above the accumulator. When the guard bit and the sign bit
  // disagree, the add left the ACCW range, and the guard bit gives the
  // direction of the clamp.
  always_comb begin
    new_ovf = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_c[i]    = {acc[i][ACCW-1], acc[i]} +
                    {{(ACCW+1-PW){s1_prod[i][PW-1]}}, s1_prod[i]};
      acc_next[i] = sum_c[i][ACCW-1:0];
      if (sum_c[i][ACCW] != sum_c[i][ACCW-1]) begin
        new_ovf[i]  = 1'b1;
        acc_next[i] = sum_c[i][ACCW] ? ACC_MIN : ACC_MAX;
      end
    end
  end

  // Only beats that produce an output need the output slot. In MODE 1,
  // non-LAST beats drain into the accumulator even while the output is stalled.
  assign emit       = (MODE == 0) || s1_last;
  assign advance    = s1_valid && (!emit || !OUT_MAC_VALID || OUT_MAC_READY);
  assign s1_free    = !s1_valid || advance;
  assign IN_READY_A = s1_free && IN_VALID_A && IN_VALID_B && !RESET;
  assign IN_READY_B = IN_READY_A;
  assign fire       = IN_READY_A;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        s1_prod[i] <= '0;
      end
    end else if (fire) begin
      s1_valid <= 1'b1;
      // A LAST mismatch still closes the packet, so either side counts.
      s1_last  <= IN_LAST_A | IN_LAST_B;
      for (int i = 0; i < LANES; i++) begin
        s1_prod[i] <= prod_c[i];
      end
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < LANES; i++) begin
        acc[i] <= '0;
      end
      ovf              <= '0;
      OUT_MAC_VALID    <= 1'b0;
      OUT_MAC_LAST     <= 1'b0;
      OUT_MAC_OVERFLOW <= '0;
      OUT_MAC_DATA     <= '0;
    end else begin
      if (advance) begin
        for (int i = 0; i < LANES; i++) begin
          acc[i] <= s1_last ? '0 : acc_next[i];
        end
        ovf <= s1_last ? '0 : (ovf | new_ovf);
      end
      if (advance && emit) begin
        OUT_MAC_VALID    <= 1'b1;
        OUT_MAC_LAST     <= s1_last;
        OUT_MAC_OVERFLOW <= ovf | new_ovf;
        for (int i = 0; i < LANES; i++) begin
          OUT_MAC_DATA[i*ACCW +: ACCW] <= acc_next[i];
        end
      end else if (OUT_MAC_READY) begin
        OUT_MAC_VALID <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      LAST_ERR <= 1'b0;
    end else if (fire && (IN_LAST_A != IN_LAST_B)) begin
      LAST_ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_int_multilane.sv
// tb/tb_mac_int_multilane.sv - self-checking bench for mac_int_multilane (MODE 0 and MODE 1 instances)
module tb_mac_int_multilane;

  localparam int W     = 8;
  localparam int LANES = 2;
  localparam int ACCW  = 16;
  localparam int DW    = W * LANES;
  localparam int OW    = ACCW * LANES;
  localparam longint ACC_HI = (longint'(1) <<< (ACCW - 1)) - 1;
  localparam longint ACC_LO = -(longint'(1) <<< (ACCW - 1));

  typedef struct packed {
    logic [OW-1:0]    data;
    logic [LANES-1:0] ovf;
    logic             last;
  } beat_t;

  logic CLK = 1'b0;
  logic RESET;
  logic [DW-1:0]    da [2];
  logic [DW-1:0]    db [2];
  logic             va [2], vb [2], la [2], lb [2], ordy [2];
  logic             ra [2], rb [2], ovalid [2], olast [2], lerr [2];
  logic [OW-1:0]    odata [2];
  logic [LANES-1:0] oovf [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  beat_t exp_q0[$], exp_q1[$], obs_q0[$], obs_q1[$];

  longint           macc [2][LANES];
  logic [LANES-1:0] movf [2];
  logic             merr [2];
  int               stab_viol [2] = '{0, 0};
  logic             held_v [2] = '{1'b0, 1'b0};
  beat_t            held [2];
  beat_t            cur, bt;
  logic             lst;
  logic signed [W-1:0] ea, eb;
  longint           s;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  mac_int_multilane #(.W(W), .LANES(LANES), .ACCW(ACCW), .MODE(0)) dut0 (
    .CLK(CLK), .RESET(RESET),
    .IN_READY_A(ra[0]), .IN_DATA_A(da[0]), .IN_VALID_A(va[0]), .IN_LAST_A(la[0]),
    .IN_READY_B(rb[0]), .IN_DATA_B(db[0]), .IN_VALID_B(vb[0]), .IN_LAST_B(lb[0]),
    .OUT_MAC_DATA(odata[0]), .OUT_MAC_VALID(ovalid[0]), .OUT_MAC_READY(ordy[0]),
    .OUT_MAC_LAST(olast[0]), .OUT_MAC_OVERFLOW(oovf[0]), .LAST_ERR(lerr[0])
  );

  mac_int_multilane #(.W(W), .LANES(LANES), .ACCW(ACCW), .MODE(1)) dut1 (
    .CLK(CLK), .RESET(RESET),
    .IN_READY_A(ra[1]), .IN_DATA_A(da[1]), .IN_VALID_A(va[1]), .IN_LAST_A(la[1]),
    .IN_READY_B(rb[1]), .IN_DATA_B(db[1]), .IN_VALID_B(vb[1]), .IN_LAST_B(lb[1]),
    .OUT_MAC_DATA(odata[1]), .OUT_MAC_VALID(ovalid[1]), .OUT_MAC_READY(ordy[1]),
    .OUT_MAC_LAST(olast[1]), .OUT_MAC_OVERFLOW(oovf[1]), .LAST_ERR(lerr[1])
  );

  // Inputs change #1 after posedge, so the values seen at negedge are what the
  // next posedge acts on: record handshakes and run the packet model here.
  always @(negedge CLK) begin
    for (int d = 0; d < 2; d++) begin
      cur = {odata[d], oovf[d], olast[d]};
      if (RESET) begin
        for (int l = 0; l < LANES; l++) macc[d][l] = 0;
        movf[d]   = '0;
        merr[d]   = 1'b0;
        held_v[d] = 1'b0;
      end else begin
        if (held_v[d] && (!ovalid[d] || cur !== held[d])) stab_viol[d]++;
        held_v[d] = ovalid[d] && !ordy[d];
        held[d]   = cur;
        if (ovalid[d] && ordy[d]) begin
          if (d == 0) obs_q0.push_back(cur);
          else        obs_q1.push_back(cur);
        end
        if (ra[d] && va[d] && vb[d]) begin
          lst = la[d] | lb[d];
          if (la[d] != lb[d]) merr[d] = 1'b1;
          bt = '0;
          for (int l = 0; l < LANES; l++) begin
            ea = da[d][l*W +: W];
            eb = db[d][l*W +: W];
            s  = macc[d][l] + longint'(ea) * longint'(eb);
            if (s > ACC_HI) begin
              s = ACC_HI;
              movf[d][l] = 1'b1;
            end else if (s < ACC_LO) begin
              s = ACC_LO;
              movf[d][l] = 1'b1;
            end
            macc[d][l] = s;
            bt.data[l*ACCW +: ACCW] = s[ACCW-1:0];
          end
          bt.ovf  = movf[d];
          bt.last = lst;
          if (d == 0) exp_q0.push_back(bt);
          else if (lst) exp_q1.push_back(bt);
          if (lst) begin
            for (int l = 0; l < LANES; l++) macc[d][l] = 0;
            movf[d] = '0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog sim time exceeded limit");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int d);
    va[d] = 1'b0; vb[d] = 1'b0; la[d] = 1'b0; lb[d] = 1'b0;
  endtask

  task automatic clear_q;
    exp_q0.delete(); exp_q1.delete(); obs_q0.delete(); obs_q1.delete();
  endtask

  // Presents one joined beat and returns #1 after the edge that accepted it;
  // valid is left high so consecutive calls stream back to back.
  task automatic send(input int d, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic l_a, input logic l_b);
    int n;
    da[d] = a; db[d] = b; la[d] = l_a; lb[d] = l_b; va[d] = 1'b1; vb[d] = 1'b1;
    n = 0;
    @(negedge CLK);
    while (!ra[d] && n < 100) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (!ra[d]) begin
      failures++;
      $display("FAIL send_accept dut=%0d got ready=0 want ready=1 within 100 cycles", d);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    for (int d = 0; d < 2; d++) begin
      da[d] = DW'($urandom); db[d] = DW'($urandom); va[d] = 1'b1; vb[d] = 1'b1;
    end
    tick(3);
    @(negedge CLK);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ra[d] !== 1'b0 || rb[d] !== 1'b0) begin
        failures++; $display("FAIL reset_ready dut=%0d got %b%b want 00", d, ra[d], rb[d]);
      end
      checks++;
      if ({ovalid[d], olast[d], lerr[d]} !== 3'b000) begin
        failures++; $display("FAIL reset_flags dut=%0d got v/l/e=%b%b%b want 000", d, ovalid[d], olast[d], lerr[d]);
      end
      checks++;
      if (odata[d] !== '0 || oovf[d] !== '0) begin
        failures++; $display("FAIL reset_data dut=%0d got %h/%b want 0/0", d, odata[d], oovf[d]);
      end
    end
    @(posedge CLK); #1;
    RESET = 1'b0;
    idle(0); idle(1);
    tick(1);
  endtask

  task automatic test_basic;
    logic [ACCW-1:0] l0 [4];
    logic [ACCW-1:0] l1 [4];
    logic            lv [4];
    l0 = '{16'd4, 16'd14, 16'd32, 16'd4};
    l1 = '{16'hFFF2, 16'hFFE4, 16'hFFD6, 16'h0000};
    lv = '{1'b0, 1'b0, 1'b1, 1'b1};
    clear_q;
    send(0, {8'hFE, 8'd1}, {8'd7, 8'd4}, 1'b0, 1'b0);
    send(0, {8'hFE, 8'd2}, {8'd7, 8'd5}, 1'b0, 1'b0);
    send(0, {8'hFE, 8'd3}, {8'd7, 8'd6}, 1'b1, 1'b1);
    send(0, {8'h00, 8'd2}, {8'd0, 8'd2}, 1'b1, 1'b1);
    idle(0); tick(6);
    checks++;
    if (obs_q0.size() != 4) begin
      failures++; $display("FAIL basic_count got %0d want 4", obs_q0.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < obs_q0.size()) begin
        checks++;
        if (obs_q0[i] !== {l1[i], l0[i], 2'b00, lv[i]}) begin
          failures++; $display("FAIL basic_beat%0d got %h want %h", i, obs_q0[i], {l1[i], l0[i], 2'b00, lv[i]});
        end
      end
    end
  endtask

  task automatic test_mode1;
    clear_q;
    send(1, {8'hFF, 8'd1}, {8'd5, 8'd2}, 1'b0, 1'b0);
    send(1, {8'hFF, 8'd1}, {8'd5, 8'd3}, 1'b0, 1'b0);
    send(1, {8'hFF, 8'd1}, {8'd5, 8'd4}, 1'b1, 1'b1);
    idle(1); tick(6);
    checks++;
    if (obs_q1.size() != 1) begin
      failures++; $display("FAIL mode1_count got %0d want 1", obs_q1.size());
    end
    if (obs_q1.size() > 0) begin
      checks++;
      if (obs_q1[0] !== {16'hFFF1, 16'd9, 2'b00, 1'b1}) begin
        failures++; $display("FAIL mode1_beat got %h want %h", obs_q1[0], {16'hFFF1, 16'd9, 2'b00, 1'b1});
      end
    end
  endtask

  task automatic test_saturation;
    beat_t tbl [4];
    tbl[0] = {16'hC080, 16'h4000, 2'b00, 1'b0};
    tbl[1] = {16'h8100, 16'h7FFF, 2'b01, 1'b0};
    tbl[2] = {16'h8000, 16'h7FFF, 2'b11, 1'b1};
    tbl[3] = {16'h0000, 16'h0001, 2'b00, 1'b1};
    clear_q;
    send(0, {8'h80, 8'h80}, {8'h7F, 8'h80}, 1'b0, 1'b0);
    send(0, {8'h80, 8'h80}, {8'h7F, 8'h80}, 1'b0, 1'b0);
    send(0, {8'h80, 8'h80}, {8'h7F, 8'h80}, 1'b1, 1'b1);
    send(0, {8'h00, 8'h01}, {8'h00, 8'h01}, 1'b1, 1'b1);
    idle(0); tick(6);
    checks++;
    if (obs_q0.size() != 4) begin
      failures++; $display("FAIL sat_count got %0d want 4", obs_q0.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < obs_q0.size()) begin
        checks++;
        if (obs_q0[i] !== tbl[i]) begin
          failures++; $display("FAIL sat_beat%0d got %h want %h", i, obs_q0[i], tbl[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    beat_t hb, got, want;
    int n, start, sv0;
    clear_q;
    sv0 = stab_viol[0];
    ordy[0] = 1'b0;
    da[0] = DW'($urandom); db[0] = DW'($urandom); la[0] = 1'b0; lb[0] = 1'b0;
    va[0] = 1'b1; vb[0] = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      checks++;
      if (ra[0] !== 1'b0 || rb[0] !== 1'b0) begin
        failures++; $display("FAIL skew_ready got %b%b want 00", ra[0], rb[0]);
      end
      @(posedge CLK); #1;
    end
    fork
      begin
        for (int i = 0; i < 6; i++) send(0, DW'($urandom), DW'($urandom), i == 5, i == 5);
        idle(0);
      end
      begin
        n = 0;
        @(negedge CLK);
        while (!ovalid[0] && n < 20) begin
          @(negedge CLK);
          n++;
        end
        checks++;
        if (!ovalid[0]) begin
          failures++; $display("FAIL bp_first_out got valid=0 want 1 within 20 cycles");
        end
        hb = {odata[0], oovf[0], olast[0]};
        for (int c = 0; c < 5; c++) begin
          checks++;
          if (ovalid[0] !== 1'b1 || {odata[0], oovf[0], olast[0]} !== hb) begin
            failures++; $display("FAIL bp_hold cycle%0d got %h want %h", c, {odata[0], oovf[0], olast[0]}, hb);
          end
          checks++;
          if (ra[0] !== 1'b0 || rb[0] !== 1'b0) begin
            failures++; $display("FAIL bp_ready_low cycle%0d got %b%b want 00", c, ra[0], rb[0]);
          end
          if (c < 4) @(negedge CLK);
        end
        @(posedge CLK); #1;
        ordy[0] = 1'b1;
      end
    join
    tick(6);
    checks++;
    if (obs_q0.size() != 6 || exp_q0.size() != 6) begin
      failures++; $display("FAIL bp_count got obs=%0d exp=%0d want 6", obs_q0.size(), exp_q0.size());
    end
    while (obs_q0.size() > 0 && exp_q0.size() > 0) begin
      got = obs_q0.pop_front();
      want = exp_q0.pop_front();
      checks++;
      if (got !== want) begin
        failures++; $display("FAIL bp_beat got %h want %h", got, want);
      end
    end
    checks++;
    if (stab_viol[0] != sv0) begin
      failures++; $display("FAIL bp_stable got %0d changes want 0", stab_viol[0] - sv0);
    end
    start = cyc;
    for (int i = 0; i < 8; i++) send(0, DW'($urandom), DW'($urandom), i == 7, i == 7);
    idle(0);
    checks++;
    if (cyc - start != 8) begin
      failures++; $display("FAIL throughput got %0d cycles want 8", cyc - start);
    end
    tick(6);
  endtask

  task automatic test_last_mismatch;
    beat_t tbl [4];
    tbl[0] = {16'd0, 16'd6, 2'b00, 1'b0};
    tbl[1] = {16'd0, 16'd26, 2'b00, 1'b1};
    tbl[2] = {16'd0, 16'd7, 2'b00, 1'b0};
    tbl[3] = {16'd0, 16'd8, 2'b00, 1'b1};
    clear_q;
    send(0, {8'd0, 8'd2}, {8'd0, 8'd3}, 1'b0, 1'b0);
    checks++;
    if (lerr[0] !== 1'b0) begin
      failures++; $display("FAIL lasterr_clear got %b want 0", lerr[0]);
    end
    send(0, {8'd0, 8'd4}, {8'd0, 8'd5}, 1'b1, 1'b0);
    send(0, {8'd0, 8'd1}, {8'd0, 8'd7}, 1'b0, 1'b0);
    send(0, {8'd0, 8'd1}, {8'd0, 8'd1}, 1'b0, 1'b1);
    idle(0); tick(6);
    checks++;
    if (lerr[0] !== 1'b1) begin
      failures++; $display("FAIL lasterr_sticky got %b want 1", lerr[0]);
    end
    checks++;
    if (obs_q0.size() != 4) begin
      failures++; $display("FAIL lasterr_count got %0d want 4", obs_q0.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < obs_q0.size()) begin
        checks++;
        if (obs_q0[i] !== tbl[i]) begin
          failures++; $display("FAIL lasterr_beat%0d got %h want %h", i, obs_q0[i], tbl[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    clear_q;
    send(0, {8'd0, 8'd1}, {8'd0, 8'd1}, 1'b0, 1'b0);
    send(0, {8'd0, 8'd2}, {8'd0, 8'd2}, 1'b0, 1'b0);
    RESET = 1'b1;
    tick(2);
    @(negedge CLK);
    checks++;
    if (ra[0] !== 1'b0 || rb[0] !== 1'b0) begin
      failures++; $display("FAIL rstmid_ready got %b%b want 00", ra[0], rb[0]);
    end
    checks++;
    if ({ovalid[0], olast[0], lerr[0]} !== 3'b000 || odata[0] !== '0 || oovf[0] !== '0) begin
      failures++; $display("FAIL rstmid_outputs got v=%b l=%b e=%b d=%h o=%b want all 0",
                           ovalid[0], olast[0], lerr[0], odata[0], oovf[0]);
    end
    @(posedge CLK); #1;
    RESET = 1'b0;
    idle(0);
    tick(1);
    clear_q;
    send(0, {8'd0, 8'd3}, {8'd0, 8'd3}, 1'b1, 1'b1);
    idle(0); tick(6);
    checks++;
    if (obs_q0.size() != 1) begin
      failures++; $display("FAIL rstmid_count got %0d want 1", obs_q0.size());
    end
    if (obs_q0.size() > 0) begin
      checks++;
      if (obs_q0[0] !== {16'd0, 16'd9, 2'b00, 1'b1}) begin
        failures++; $display("FAIL rstmid_beat got %h want %h", obs_q0[0], {16'd0, 16'd9, 2'b00, 1'b1});
      end
    end
  endtask

  task automatic test_random;
    beat_t got, want;
    int n_obs, n_exp;
    bit done;
    for (int d = 0; d < 2; d++) begin
      clear_q;
      done = 1'b0;
      fork
        begin
          for (int i = 0; i < 60; i++) begin
            logic lr, mm;
            lr = ($urandom_range(0, 4) == 0) || (i == 59);
            mm = ($urandom_range(0, 9) == 0);
            send(d, DW'($urandom), DW'($urandom), lr, lr ^ mm);
            if ($urandom_range(0, 3) == 0) begin
              idle(d);
              tick($urandom_range(1, 3));
            end
          end
          idle(d);
          done = 1'b1;
        end
        begin
          while (!done) begin
            ordy[d] = ($urandom_range(0, 2) != 0);
            tick(1);
          end
          ordy[d] = 1'b1;
        end
      join
      tick(8);
      n_obs = (d == 0) ? obs_q0.size() : obs_q1.size();
      n_exp = (d == 0) ? exp_q0.size() : exp_q1.size();
      checks++;
      if (n_obs != n_exp || n_exp == 0) begin
        failures++; $display("FAIL rand_count dut=%0d got %0d want %0d", d, n_obs, n_exp);
      end
      for (int i = 0; i < n_obs && i < n_exp; i++) begin
        got  = (d == 0) ? obs_q0[i] : obs_q1[i];
        want = (d == 0) ? exp_q0[i] : exp_q1[i];
        checks++;
        if (got !== want) begin
          failures++; $display("FAIL rand_beat dut=%0d idx=%0d got %h want %h", d, i, got, want);
        end
      end
      checks++;
      if (lerr[d] !== merr[d]) begin
        failures++; $display("FAIL rand_lasterr dut=%0d got %b want %b", d, lerr[d], merr[d]);
      end
      checks++;
      if (stab_viol[d] != 0) begin
        failures++; $display("FAIL rand_stable dut=%0d got %0d changes want 0", d, stab_viol[d]);
      end
    end
  endtask

  initial begin
    RESET = 1'b1;
    for (int d = 0; d < 2; d++) begin
      idle(d);
      da[d] = '0; db[d] = '0; ordy[d] = 1'b1;
    end
    test_reset;
    test_basic;
    test_mode1;
    test_saturation;
    test_backpressure;
    test_last_mismatch;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
